lattice_stream_scheduler: RTL

- Sequences the read-out of one full lattice frame (DEPTH pixels, 9 x 16-bit directions each) from the lattice BRAM read port onto a 144-bit AXI4-Stream master.
- Shares the BRAM read port with the collision/streaming compute engine; the compute engine has fixed priority.
- Correctly accounts for BRAM read latency and downstream tready backpressure using a credit-controlled output FIFO.
- Sits between the lattice BRAM and the DMA/host stream.

---
 rtl/lattice_stream_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lattice_stream_scheduler.sv
// Lattice frame read-out scheduler: shares the BRAM read port with the
// compute engine and streams DEPTH pixels through a credit-checked FIFO.
module lattice_stream_scheduler #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12,
  parameter int READ_LATENCY  = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      m00_axis_aclk,
  input  logic                      m00_axis_aresetn,
  input  logic                      frame_ready,
  input  logic                      comp_req,
  input  logic [ADDRESS_WIDTH-1:0]  comp_addr,
  output logic                      comp_grant,
  output logic                      bram_en,
  output logic [ADDRESS_WIDTH-1:0]  bram_addr,
  input  logic [9*DATA_WIDTH-1:0]   bram_dout,
  output logic                      busy,
  output logic                      frame_done,
  input  logic                      m00_axis_tready,
  output logic                      m00_axis_tvalid,
  output logic [9*DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [9*DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                      m00_axis_tlast
);

  localparam int BW = 9 * DATA_WIDTH;
  localparam int IW = ADDRESS_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(READ_LATENCY + 1);

  localparam logic [IW-1:0] LAST_ADDR = IW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_MAX   = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [IW-1:0]           issue_addr;
  logic                    issue_last;
  logic                    credit_ok;
  logic                    stream_issue;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [LW-1:0]           inflight;

  logic [BW-1:0]           fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_lst;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           fifo_count;
  logic                    push;
  logic                    pop;
  logic                    drained;

  assign issue_last = (issue_addr == LAST_ADDR);

  // Credit: every in-flight read already owns a FIFO slot.
  assign credit_ok = (32'(fifo_count) + 32'(inflight))
                   < 32'(FIFO_DEPTH);

  // Compute engine has fixed priority over the stream.
  assign comp_grant = comp_req & m00_axis_aresetn;

  assign stream_issue = (state == STREAM)
                      && (issue_addr <= LAST_ADDR)
                      && credit_ok
                      && !comp_req;

  assign bram_en = comp_grant | stream_issue;

  // Address mux: compute address, stream address, else zero.
  always_comb begin
    bram_addr = '0;
    unique case (1'b1)
      comp_grant:   bram_addr = comp_addr;
      stream_issue: bram_addr = issue_addr[ADDRESS_WIDTH-1:0];
      default:      bram_addr = '0;
    endcase
  end

  // Count the valid stages of the read pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + LW'(pipe_vld[i]);
    end
  end

  assign push    = pipe_vld[READ_LATENCY-1];
  assign pop     = m00_axis_tvalid & m00_axis_tready;
  assign drained = (inflight == '0) && (fifo_count == '0);

  // Frame sequencing and the end-of-frame pulse.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_ready) state_next = STREAM;
      end
      STREAM: begin
        if (stream_issue && issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stream issue address; wide enough to reach DEPTH without wrap.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      issue_addr <= '0;
    end else if (state == IDLE && frame_ready) begin
      issue_addr <= '0;
    end else if (stream_issue) begin
      issue_addr <= issue_addr + 1'b1;
    end
  end

  // Shift register tracking stream reads through the BRAM latency.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= stream_issue;
      pipe_last[0] <= stream_issue & issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are qualified by fifo_count.
  always_ff @(posedge m00_axis_aclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bram_dout;
      fifo_lst[wr_ptr] <= pipe_last[READ_LATENCY-1];
    end
  end

  assign m00_axis_tvalid = (fifo_count != '0);
  assign m00_axis_tdata  = m00_axis_tvalid ? fifo_mem[rd_ptr] : '0;
  assign m00_axis_tlast  = m00_axis_tvalid & fifo_lst[rd_ptr];
  assign m00_axis_tstrb  = '1;
  assign busy            = (state != IDLE);

endmodule
